// File: rtl/mem_stage_pkg.sv
// Shared types for the memory pipeline stage: size codes, FSM states, X/M record.
// Optional misaligned-access trap is enabled by MEM_STAGE_MISALIGN_TRAP_EN in mem_stage.
package mem_stage_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;
    localparam int DATA_W    = NUM_LANES * LANE_W;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_e;

    // pend marks an op that still has to reach M/W
    typedef struct packed {
        logic              pend;
        logic              load;
        logic              store;
        size_e             size;
        logic              uns;
        logic              dest;
        logic [4:0]        rd;
        logic [DATA_W-1:0] result;
    } xm_t;

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        return ((sz == SZ_WORD) && (off != 2'b00)) || ((sz == SZ_HALF) && off[0]);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Sub-word lane logic: byte enables, store replication, load extract and extend.
// Lane 0 is the most significant byte (big-endian); be[3] enables lane 0.
module mem_align
    import mem_stage_pkg::*;
(
    input  size_e                 size,
    input  logic [1:0]            offset,
    input  logic                  uns,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [DATA_W-1:0]     rdata,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     load_data,
    output logic [NUM_LANES-1:0]  be
);

    logic [NUM_LANES-1:0][LANE_W-1:0] rd_lanes;
    logic [LANE_W-1:0]                byte_sel;
    logic [2*LANE_W-1:0]              half_sel;

    assign rd_lanes = rdata;
    assign byte_sel = rd_lanes[2'd3 - offset];
    assign half_sel = offset[1] ? rdata[15:0] : rdata[31:16];

    // packed index j holds big-endian lane K
    for (genvar j = 0; j < NUM_LANES; j++) begin : g_be
        localparam logic [1:0] K = 2'(NUM_LANES - 1 - j);
        assign be[j] = (size == SZ_BYTE) ? (offset == K) :
                       (size == SZ_HALF) ? (K[1] == offset[1]) : 1'b1;
    end

    always_comb begin
        wdata     = store_data;
        load_data = rdata;
        case (size)
            SZ_BYTE: begin
                wdata     = {NUM_LANES{store_data[7:0]}};
                load_data = {{24{~uns & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{~uns & half_sel[15]}}, half_sel};
            end
            default: begin
                wdata     = store_data;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: X/M capture, one data access per load/store, M/W register and upstream stall.
// Define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned word/half accesses instead of masking.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] START_ADDRESS = 32'h80020000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_result,
    input  logic [ADDR_W-1:0] ex_store_data,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic              ex_dest,
    input  logic [4:0]        ex_rd,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic              mem_busy,
    output logic              stall_out,
    output logic [4:0]        xm_rd,
    output logic              xm_dest,
    output logic [ADDR_W-1:0] xm_value,
    output logic              wb_valid,
    output logic              wb_dest,
    output logic [4:0]        wb_rd,
    output logic [ADDR_W-1:0] wb_data,
    output logic              mem_fault
);

    state_e            state;
    xm_t               xm;
    logic              wb_load;
    logic              fault_ex;
    logic              idle;
    logic              fwd;
    size_e             ex_sz;
    size_e             al_size;
    logic [1:0]        al_off;
    logic              al_uns;
    logic [ADDR_W-1:0] st_src;
    logic [ADDR_W-1:0] al_wdata;
    logic [ADDR_W-1:0] al_load;
    logic [3:0]        al_be;

    assign idle  = (state == IDLE);
    assign ex_sz = size_e'(ex_size);

    // For stores ex_rd carries the rt index; a load that just reached M/W overrides the stale rt value
    assign fwd    = ex_store && wb_valid && wb_load && (ex_rd == wb_rd);
    assign st_src = fwd ? wb_data : ex_store_data;

    // One aligner: request side uses the incoming op in IDLE, load side uses X/M during the access
    assign al_size = idle ? ex_sz            : xm.size;
    assign al_off  = idle ? ex_result[1:0]   : xm.result[1:0];
    assign al_uns  = idle ? ex_unsigned      : xm.uns;

    mem_align u_align (
        .size       (al_size),
        .offset     (al_off),
        .uns        (al_uns),
        .store_data (st_src),
        .rdata      (mem_rdata),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .be         (al_be)
    );

    assign stall_out = !idle || (xm.pend && (xm.load || xm.store));
    assign xm_rd     = xm.rd;
    assign xm_dest   = xm.pend && xm.dest && !xm.load && !xm.store;
    assign xm_value  = xm.result;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic fault_q;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) fault_q <= 1'b0;
        else         fault_q <= idle && stall_out;
    end
    assign mem_fault = fault_q;
    assign fault_ex  = misaligned(ex_sz, ex_result[1:0]);
`else
    assign mem_fault = 1'b0;
    assign fault_ex  = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            xm        <= '0;
            mem_req   <= 1'b0;
            mem_wren  <= 1'b0;
            mem_addr  <= START_ADDRESS;
            mem_wdata <= '0;
            mem_be    <= '0;
            wb_valid  <= 1'b0;
            wb_dest   <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_load   <= 1'b0;
        end else begin
            mem_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (stall_out) begin
                        // only a trapped misaligned op can sit here; retire it without a write
                        wb_valid <= 1'b1;
                        wb_dest  <= 1'b0;
                        wb_rd    <= xm.rd;
                        wb_data  <= xm.result;
                        wb_load  <= 1'b0;
                        xm.pend  <= 1'b0;
                    end else begin
                        wb_valid <= xm.pend;
                        wb_dest  <= xm.pend && xm.dest;
                        wb_rd    <= xm.rd;
                        wb_data  <= xm.result;
                        wb_load  <= 1'b0;
                        xm <= '{pend: ex_valid, load: ex_load, store: ex_store, size: ex_sz,
                                uns: ex_unsigned, dest: ex_dest, rd: ex_rd, result: ex_result};
                        if (ex_valid && (ex_load || ex_store) && !fault_ex) begin
                            state     <= ACCESS;
                            mem_req   <= 1'b1;
                            mem_wren  <= ex_store;
                            mem_addr  <= {ex_result[ADDR_W-1:2], 2'b00};
                            mem_wdata <= al_wdata;
                            mem_be    <= al_be;
                        end
                    end
                end
                ACCESS, WAIT: begin
                    if (!mem_busy) begin
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        wb_dest  <= xm.load && xm.dest;
                        wb_rd    <= xm.rd;
                        wb_data  <= xm.load ? al_load : xm.result;
                        wb_load  <= xm.load;
                        xm.pend  <= 1'b0;
                    end else begin
                        state    <= WAIT;
                        wb_valid <= 1'b0;
                        wb_dest  <= 1'b0;
                        wb_load  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, corner sequences, random ops vs model.
module tb_mem_stage;

    logic        clock, resetn;
    logic        ex_valid, ex_load, ex_store, ex_unsigned, ex_dest;
    logic [31:0] ex_result, ex_store_data, mem_rdata;
    logic [1:0]  ex_size;
    logic [4:0]  ex_rd;
    logic        mem_req, mem_wren, mem_busy, stall_out, xm_dest;
    logic        wb_valid, wb_dest, mem_fault;
    logic [31:0] mem_addr, mem_wdata, xm_value, wb_data;
    logic [3:0]  mem_be;
    logic [4:0]  xm_rd, wb_rd;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clock(clock), .resetn(resetn), .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .ex_load(ex_load), .ex_store(ex_store),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_dest(ex_dest), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_busy(mem_busy), .stall_out(stall_out),
        .xm_rd(xm_rd), .xm_dest(xm_dest), .xm_value(xm_value), .wb_valid(wb_valid),
        .wb_dest(wb_dest), .wb_rd(wb_rd), .wb_data(wb_data), .mem_fault(mem_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ld, st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr, sdata, rdata;
        logic [4:0]  rd;
        int          busy;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_val;   // store data on the bus, or loaded register value
    } vec_t;

    typedef struct {
        logic [31:0] addr, wdata, wb_data;
        logic [3:0]  be;
        logic        wren, held, wb_valid, wb_dest, stall_after;
        logic [4:0]  wb_rd;
        int          req, stalls;
    } res_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---- reference model: arithmetic on the lane rules ----
    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'b10) return 4'b1000 >> off;
        if (sz == 2'b01) return off[1] ? 4'b0011 : 4'b1100;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b10) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] off,
                                           input logic uns, input logic [31:0] r);
        logic [31:0] v;
        if (sz == 2'b10) begin
            v = (r >> (8 * (3 - off))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 2'b01) begin
            v = (r >> (off[1] ? 0 : 16)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    // Issue one load/store from IDLE and run it to completion with busy_n busy cycles
    task automatic do_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                         input logic [4:0] rd, input int busy_n, output res_t r);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_size = sz; ex_unsigned = uns;
        ex_result = addr; ex_store_data = sdata; ex_dest = ld; ex_rd = rd;
        mem_rdata = rdata; mem_busy = 1'b0;
        step();
        ex_valid = 1'b0;
        r.addr = mem_addr; r.be = mem_be; r.wdata = mem_wdata; r.wren = mem_wren;
        r.req = 0; r.stalls = 0; r.held = 1'b1;
        for (int c = 0; c <= busy_n; c++) begin
            mem_busy = (c < busy_n);
            if (mem_req) r.req++;
            if (stall_out) r.stalls++;
            if (mem_addr !== r.addr || mem_be !== r.be || mem_wdata !== r.wdata || mem_wren !== r.wren)
                r.held = 1'b0;
            step();
        end
        mem_busy = 1'b0;
        r.wb_valid = wb_valid; r.wb_dest = wb_dest; r.wb_rd = wb_rd; r.wb_data = wb_data;
        r.stall_after = stall_out;
        chk("bus_hold", r.held, 1'b1);
    endtask

    task automatic do_alu(input logic [31:0] res, input logic dst, input logic [4:0] rd);
        ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0; ex_size = 2'b00;
        ex_result = res; ex_dest = dst; ex_rd = rd;
        #1 chk("alu_stall_pre", stall_out, 1'b0);
        step();
        chk("alu_xm_value", xm_value, res);
        chk("alu_xm_dest", xm_dest, dst);
        chk("alu_stall_mid", stall_out, 1'b0);
        ex_valid = 1'b0;
        step();
        chk("alu_wb_valid", wb_valid, 1'b1);
        chk("alu_wb_dest", wb_dest, dst);
        chk("alu_wb_rd", wb_rd, rd);
        chk("alu_wb_data", wb_data, res);
        chk("alu_stall_post", stall_out, 1'b0);
    endtask

    vec_t tbl[9];
    int   nvec;
    res_t r;

    initial begin
        resetn = 1'b0; ex_valid = 0; ex_load = 0; ex_store = 0; ex_size = 0; ex_unsigned = 0;
        ex_dest = 0; ex_rd = 0; ex_result = 0; ex_store_data = 0; mem_rdata = 0; mem_busy = 0;

        // ---- reset state ----
        step(); step();
        chk("rst_mem_addr", mem_addr, 32'h80020000);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_be", mem_be, 4'b0000);
        chk("rst_stall", stall_out, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_fault", mem_fault, 1'b0);
        resetn = 1'b1;
        step();

        // ---- ALU passthrough ----
        do_alu(32'h00000005, 1'b1, 5'd8);

        // ---- directed vector table ----
        //          ld st  sz    uns addr          sdata         rdata         rd  busy e_addr        e_be     e_val
        tbl[0] = '{1, 0, 2'b10, 0, 32'h80020001, 32'h0,        32'h12F45678, 3, 0, 32'h80020000, 4'b0100, 32'hFFFFFFF4};
        tbl[1] = '{0, 1, 2'b01, 0, 32'h80020002, 32'h0000BEEF, 32'h0,        5, 3, 32'h80020000, 4'b0011, 32'hBEEFBEEF};
        tbl[2] = '{1, 0, 2'b10, 1, 32'h80020003, 32'h0,        32'h12F45678, 6, 0, 32'h80020000, 4'b0001, 32'h00000078};
        tbl[3] = '{1, 0, 2'b01, 0, 32'h80020000, 32'h0,        32'h80011234, 7, 1, 32'h80020000, 4'b1100, 32'hFFFF8001};
        tbl[4] = '{1, 0, 2'b01, 1, 32'h80020002, 32'h0,        32'h8001F00D, 9, 0, 32'h80020000, 4'b0011, 32'h0000F00D};
        tbl[5] = '{1, 0, 2'b00, 0, 32'h80020004, 32'h0,        32'hDEADBEEF, 10, 2, 32'h80020004, 4'b1111, 32'hDEADBEEF};
        tbl[6] = '{0, 1, 2'b10, 0, 32'h80020000, 32'h123456A5, 32'h0,        11, 1, 32'h80020000, 4'b1000, 32'hA5A5A5A5};
        tbl[7] = '{0, 1, 2'b00, 0, 32'h80020008, 32'h01234567, 32'h0,        12, 0, 32'h80020008, 4'b1111, 32'h01234567};
        tbl[8] = '{1, 0, 2'b00, 0, 32'h80020003, 32'h0,        32'h11223344, 13, 0, 32'h80020000, 4'b1111, 32'h11223344};
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        nvec = 8;
`else
        nvec = 9;
`endif
        for (int i = 0; i < nvec; i++) begin
            do_op(tbl[i].ld, tbl[i].st, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].sdata,
                  tbl[i].rdata, tbl[i].rd, tbl[i].busy, r);
            chk($sformatf("v%0d_addr", i), r.addr, tbl[i].e_addr);
            chk($sformatf("v%0d_be", i), r.be, tbl[i].e_be);
            chk($sformatf("v%0d_wren", i), r.wren, tbl[i].st);
            chk($sformatf("v%0d_req", i), r.req, 1);
            chk($sformatf("v%0d_stalls", i), r.stalls, tbl[i].busy + 1);
            chk($sformatf("v%0d_wb_valid", i), r.wb_valid, 1'b1);
            chk($sformatf("v%0d_wb_dest", i), r.wb_dest, tbl[i].ld);
            chk($sformatf("v%0d_stall_after", i), r.stall_after, 1'b0);
            if (tbl[i].st) chk($sformatf("v%0d_wdata", i), r.wdata, tbl[i].e_val);
            else           chk($sformatf("v%0d_wb_data", i), r.wb_data, tbl[i].e_val);
            step();
            chk($sformatf("v%0d_bubble_valid", i), wb_valid, 1'b0);
            chk($sformatf("v%0d_bubble_dest", i), wb_dest, 1'b0);
        end

        // ---- load->store forward, then no forward after a store ----
        do_op(1, 0, 2'b00, 0, 32'h80020010, 32'h0, 32'hCAFEF00D, 5'd4, 1, r);
        chk("fwd_lw_data", r.wb_data, 32'hCAFEF00D);
        do_op(0, 1, 2'b00, 0, 32'h80020014, 32'h11111111, 32'h0, 5'd4, 0, r);
        chk("fwd_sw_wdata", r.wdata, 32'hCAFEF00D);
        do_op(0, 1, 2'b00, 0, 32'h80020018, 32'h22222222, 32'h0, 5'd4, 0, r);
        chk("nofwd_sw_wdata", r.wdata, 32'h22222222);
        step();

        // ---- reset during WAIT ----
        ex_valid = 1; ex_load = 1; ex_store = 0; ex_size = 2'b00; ex_result = 32'h80020020;
        ex_dest = 1; ex_rd = 5'd9; mem_busy = 1'b1;
        step();
        ex_valid = 0;
        step(); step();
        chk("wait_stall", stall_out, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rstw_stall", stall_out, 1'b0);
        chk("rstw_wb_valid", wb_valid, 1'b0);
        chk("rstw_mem_addr", mem_addr, 32'h80020000);
        chk("rstw_mem_req", mem_req, 1'b0);
        mem_busy = 1'b0;
        step();
        resetn = 1'b1;
        step();
        chk("rstw_no_wb", wb_valid, 1'b0);
        chk("rstw_idle", stall_out, 1'b0);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        // ---- misaligned word traps ----
        ex_valid = 1; ex_load = 1; ex_store = 0; ex_size = 2'b00; ex_result = 32'h80020003;
        ex_dest = 1; ex_rd = 5'd2;
        step();
        ex_valid = 0;
        chk("mis_no_req", mem_req, 1'b0);
        chk("mis_stall", stall_out, 1'b1);
        step();
        chk("mis_fault", mem_fault, 1'b1);
        chk("mis_wb_valid", wb_valid, 1'b1);
        chk("mis_wb_dest", wb_dest, 1'b0);
        chk("mis_no_req2", mem_req, 1'b0);
        step();
        chk("mis_fault_clear", mem_fault, 1'b0);
`endif

        // ---- randomized ops against the model ----
        begin
            logic        fwd_armed;
            logic [4:0]  fwd_rd;
            logic [31:0] fwd_data;
            fwd_armed = 1'b0; fwd_rd = '0; fwd_data = '0;
            for (int i = 0; i < 80; i++) begin
                int          kind, busy;
                logic [1:0]  sz, off;
                logic        uns, ld;
                logic [4:0]  rd;
                logic [31:0] addr, sdata, rdata, src, e_wb;
                kind = $urandom_range(0, 3);
                if (kind == 3) begin
                    ex_valid = 0;
                    step();
                    chk("rnd_idle_bubble", wb_valid, 1'b0);
                    fwd_armed = 1'b0;
                end else if (kind == 0) begin
                    do_alu($urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)));
                    fwd_armed = 1'b0;
                end else begin
                    ld    = (kind == 1);
                    sz    = 2'($urandom_range(0, 2));
                    off   = (sz == 2'b10) ? 2'($urandom_range(0, 3)) :
                            (sz == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
                    addr  = 32'h80020000 + ($urandom_range(0, 255) << 2) + 32'(off);
                    uns   = 1'($urandom_range(0, 1));
                    sdata = $urandom;
                    rdata = $urandom;
                    rd    = 5'($urandom_range(1, 6));
                    busy  = $urandom_range(0, 3);
                    src   = (!ld && fwd_armed && fwd_rd == rd) ? fwd_data : sdata;
                    e_wb  = m_load(sz, off, uns, rdata);
                    do_op(ld, !ld, sz, uns, addr, sdata, rdata, rd, busy, r);
                    chk("rnd_addr", r.addr, addr & 32'hFFFFFFFC);
                    chk("rnd_be", r.be, m_be(sz, off));
                    chk("rnd_req", r.req, 1);
                    chk("rnd_stalls", r.stalls, busy + 1);
                    chk("rnd_wb_valid", r.wb_valid, 1'b1);
                    chk("rnd_wb_dest", r.wb_dest, ld);
                    if (ld) chk("rnd_wb_data", r.wb_data, e_wb);
                    else    chk("rnd_wdata", r.wdata, m_wdata(sz, src));
                    fwd_armed = ld; fwd_rd = rd; fwd_data = e_wb;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
